// File: rtl/mips_multicycle.sv
// Multicycle MIPS-subset core: one FSM-sequenced datapath sharing a single req/ready memory port.
// Define MIPS_MC_ILLEGAL_TRAP_EN to halt on reserved opcode/funct (adds Illegal); else they are nops.
module mips_multicycle #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      NREGS    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  output logic             MemReq,
  output logic             MemWe,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWData,
  input  logic [WIDTH-1:0] MemRData,
  input  logic             MemReady,
  output logic [WIDTH-1:0] PcOut,
  output logic [WIDTH-1:0] AluResult,
  output logic [4:0]       WriteReg,
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  output logic             Retire,
  output logic             Illegal
`else
  output logic             Retire
`endif
);

  localparam int unsigned RegAw = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StExecI, StMemRd, StMemWr,
    StBranch, StJump, StWbR, StWbI, StWbMem, StHalt
  } stateT;

  stateT            state;
  logic [WIDTH-1:0] pc, regA, regB, aluOut, mdr;
  logic [31:0]      ir;
  logic [WIDTH-1:0] regs [NREGS];

  logic [5:0]       opcode, funct;
  logic [4:0]       rs, rt, rd;
  logic [15:0]      imm;
  logic [WIDTH-1:0] immSext, immZext, aluR, aluI, branchPc, jumpTarget;
  logic             rLegal, legal, taken;

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign imm     = ir[15:0];
  assign immSext = {{(WIDTH-16){imm[15]}}, imm};
  assign immZext = {{(WIDTH-16){1'b0}}, imm};

  assign PcOut     = pc;
  assign AluResult = aluOut;

  function automatic logic [WIDTH-1:0] wordAlign(input logic [WIDTH-1:0] a);
    return {a[WIDTH-1:2], 2'b00};
  endfunction

  always_comb begin
    aluR   = '0;
    rLegal = 1'b1;
    case (funct)
      FnAdd:   aluR = regA + regB;
      FnSub:   aluR = regA - regB;
      FnAnd:   aluR = regA & regB;
      FnOr:    aluR = regA | regB;
      FnSlt:   aluR = {{(WIDTH-1){1'b0}}, $signed(regA) < $signed(regB)};
      default: rLegal = 1'b0;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OpRtype:                                        legal = rLegal;
      OpJ, OpBeq, OpBne, OpAddi, OpOri, OpLw, OpSw:   legal = 1'b1;
      default:                                        legal = 1'b0;
    endcase
  end

  // lw/sw share the addi adder; ori is the only zero-extended form
  assign aluI       = (opcode == OpOri) ? (regA | immZext) : (regA + immSext);
  assign taken      = (opcode == OpBeq) ? (regA == regB) : (regA != regB);
  assign branchPc   = taken ? aluOut : pc;
  assign jumpTarget = {pc[WIDTH-1:28], ir[25:0], 2'b00};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= StFetch;
      pc        <= RESET_PC;
      ir        <= '0;
      regA      <= '0;
      regB      <= '0;
      aluOut    <= '0;
      mdr       <= '0;
      MemReq    <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
      WriteReg  <= '0;
      Retire    <= 1'b0;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      Illegal   <= 1'b0;
`endif
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      Retire <= 1'b0;
      unique case (state)
        StFetch: begin
          // Only the first fetch after reset arrives here with no request raised
          if (!MemReq) begin
            MemReq  <= 1'b1;
            MemWe   <= 1'b0;
            MemAddr <= wordAlign(pc);
          end else if (MemReady) begin
            ir     <= MemRData[31:0];
            pc     <= pc + WIDTH'(4);
            MemReq <= 1'b0;
            state  <= StDecode;
          end
        end
        StDecode: begin
          regA   <= regs[rs[RegAw-1:0]];
          regB   <= regs[rt[RegAw-1:0]];
          aluOut <= pc + (immSext << 2);
          if (!legal) begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            pc      <= pc - WIDTH'(4);
            Illegal <= 1'b1;
            state   <= StHalt;
`else
            Retire  <= 1'b1;
            MemReq  <= 1'b1;
            MemWe   <= 1'b0;
            MemAddr <= wordAlign(pc);
            state   <= StFetch;
`endif
          end else begin
            case (opcode)
              OpRtype:      state <= StExecR;
              OpBeq, OpBne: state <= StBranch;
              OpJ:          state <= StJump;
              default:      state <= StExecI;
            endcase
          end
        end
        StExecR: begin
          aluOut <= aluR;
          state  <= StWbR;
        end
        StExecI: begin
          aluOut <= aluI;
          if (opcode == OpLw || opcode == OpSw) begin
            MemReq   <= 1'b1;
            MemWe    <= (opcode == OpSw);
            MemAddr  <= wordAlign(aluI);
            MemWData <= regB;
            state    <= (opcode == OpSw) ? StMemWr : StMemRd;
          end else begin
            state <= StWbI;
          end
        end
        StMemRd: begin
          if (MemReady) begin
            mdr    <= MemRData;
            MemReq <= 1'b0;
            state  <= StWbMem;
          end
        end
        StMemWr: begin
          if (MemReady) begin
            Retire  <= 1'b1;
            MemWe   <= 1'b0;
            MemAddr <= wordAlign(pc);
            state   <= StFetch;
          end
        end
        StBranch: begin
          pc      <= branchPc;
          Retire  <= 1'b1;
          MemReq  <= 1'b1;
          MemWe   <= 1'b0;
          MemAddr <= wordAlign(branchPc);
          state   <= StFetch;
        end
        StJump: begin
          pc      <= jumpTarget;
          Retire  <= 1'b1;
          MemReq  <= 1'b1;
          MemWe   <= 1'b0;
          MemAddr <= wordAlign(jumpTarget);
          state   <= StFetch;
        end
        StWbR, StWbI, StWbMem: begin
          if (state == StWbR) begin
            if (rd[RegAw-1:0] != '0) regs[rd[RegAw-1:0]] <= aluOut;
            WriteReg <= rd;
          end else begin
            if (rt[RegAw-1:0] != '0) regs[rt[RegAw-1:0]] <= (state == StWbMem) ? mdr : aluOut;
            WriteReg <= rt;
          end
          Retire  <= 1'b1;
          MemReq  <= 1'b1;
          MemWe   <= 1'b0;
          MemAddr <= wordAlign(pc);
          state   <= StFetch;
        end
        StHalt: ;
        default: state <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Scoreboard bench for mips_multicycle: an ISA-level model predicts each retirement and store,
// and monitors compare them as the core presents Retire pulses and completed memory writes.
module tb_mips_multicycle;

  localparam int MemWords = 2048;

  logic        Clk, Rst;
  logic        MemReq, MemWe, MemReady, Retire;
  logic [31:0] MemAddr, MemWData, MemRData, PcOut, AluResult;
  logic [4:0]  WriteReg;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  logic        Illegal;
`endif

  mips_multicycle dut (
    .Clk(Clk), .Rst(Rst), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData), .MemReady(MemReady), .PcOut(PcOut),
    .AluResult(AluResult), .WriteReg(WriteReg), .Retire(Retire)
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    , .Illegal(Illegal)
`endif
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wreg;
    bit          wr;
    logic [31:0] regVal;
    bit          aluChk;
    logic [31:0] aluVal;
    int          cyc;
  } expT;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } storeT;

  expT         expQ[$];
  storeT       storeQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] prog [MemWords];
  logic [31:0] ram  [MemWords];
  logic [31:0] mregs [32];
  logic [31:0] mmem [MemWords];
  int          waitCfg = 0;
  int          memCnt = 0;
  int          loadGen = 0;
  int          loadedGen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] encR(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                       logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] encI(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                       logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] randInstr(logic [31:0] pcAddr);
    logic [5:0]  fns [5];
    logic [4:0]  rs, rt, rd;
    logic [31:0] tgt;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return encR(rs, rt, rd, fns[$urandom_range(0, 4)]);
      4: return encI(6'h08, rs, rt, 16'($urandom));
      5: return encI(6'h0D, rs, rt, 16'($urandom));
      6: return encI(6'h23, 5'd0, rt, 16'(32'h1000 + $urandom_range(0, 255)));
      7: return encI(6'h2B, 5'd0, rt, 16'(32'h1000 + $urandom_range(0, 255)));
      8: return encI(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rs, rt,
                     16'($urandom_range(0, 3)));
      default: begin
        tgt = pcAddr + 4 + 4 * $urandom_range(0, 3);
        return {6'h02, tgt[27:2]};
      end
    endcase
  endfunction

  task automatic fillRandom();
    for (int i = 0; i < 512; i++) prog[i] = randInstr(32'(i * 4));
    for (int i = 512; i < MemWords; i++) prog[i] = $urandom;
  endtask

  // Architectural model: executes instructions in program order from the ISA rules
  task automatic modelRun(input int limit, input int w, output bit halted,
                          output logic [31:0] haltPc);
    logic [31:0] pc, ins, npc, a, b, sx, zx, val, addr;
    logic [5:0]  op;
    logic [4:0]  dest, lastW;
    bit          wr, legal, alu;
    int          cyc;
    for (int i = 0; i < 32; i++) mregs[i] = 0;
    for (int i = 0; i < MemWords; i++) mmem[i] = prog[i];
    pc = 0; lastW = 0; halted = 0; haltPc = 0;
    for (int n = 0; n < limit; n++) begin
      ins = mmem[pc[12:2]];
      op = ins[31:26];
      sx = {{16{ins[15]}}, ins[15:0]};
      zx = {16'h0, ins[15:0]};
      a = mregs[ins[25:21]];
      b = mregs[ins[20:16]];
      npc = pc + 4; wr = 0; legal = 1; alu = 0; dest = ins[20:16]; val = 0; cyc = 0;
      case (op)
        6'h00: begin
          dest = ins[15:11]; wr = 1; alu = 1; cyc = 4 + w;
          case (ins[5:0])
            6'h20: val = a + b;
            6'h22: val = a - b;
            6'h24: val = a & b;
            6'h25: val = a | b;
            6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin legal = 0; wr = 0; alu = 0; end
          endcase
        end
        6'h08: begin wr = 1; alu = 1; val = a + sx; cyc = 4 + w; end
        6'h0D: begin wr = 1; alu = 1; val = a | zx; cyc = 4 + w; end
        6'h23: begin
          addr = (a + sx) & 32'hFFFF_FFFC;
          val = mmem[addr[12:2]]; wr = 1; cyc = 5 + 2 * w;
        end
        6'h2B: begin
          addr = (a + sx) & 32'hFFFF_FFFC;
          mmem[addr[12:2]] = b;
          storeQ.push_back('{addr: addr, data: b});
          cyc = 4 + 2 * w;
        end
        6'h04: begin if (a == b) npc = pc + 4 + (sx << 2); cyc = 3 + w; end
        6'h05: begin if (a != b) npc = pc + 4 + (sx << 2); cyc = 3 + w; end
        6'h02: begin npc = {npc[31:28], ins[25:0], 2'b00}; cyc = 3 + w; end
        default: legal = 0;
      endcase
      if (!legal) begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        halted = 1;
        haltPc = pc;
        break;
`else
        cyc = 2 + w;
`endif
      end
      if (wr) begin
        if (dest != 0) mregs[dest] = val;
        lastW = dest;
      end
      expQ.push_back('{pc: npc, wreg: lastW, wr: wr, regVal: (dest == 0) ? 32'd0 : val,
                       aluChk: alu, aluVal: val, cyc: cyc});
      pc = npc;
    end
  endtask

  // Memory model: waitCfg wait cycles per access, stray MemReady noise while idle
  logic        prevPending = 0;
  logic [31:0] prevAddr, prevWData;
  logic        prevWe;

  always @(negedge Clk) begin
    if (Rst || !MemReq) begin
      MemReady = 1'($urandom_range(0, 1));
      MemRData = $urandom;
    end else begin
      MemReady = (memCnt >= waitCfg);
      MemRData = ram[MemAddr[12:2]];
    end
    if (!Rst && prevPending) begin
      chk("hold_req", 32'(MemReq), 32'd1);
      chk("hold_addr", MemAddr, prevAddr);
      chk("hold_we", 32'(MemWe), 32'(prevWe));
      if (prevWe) chk("hold_wdata", MemWData, prevWData);
    end
    if (!Rst && MemReq) chk("addr_align", 32'(MemAddr[1:0]), 32'd0);
    if (!Rst && MemReq && MemWe && MemReady) begin
      if (storeQ.size() == 0) begin
        chk("unexpected_store_addr", MemAddr, 32'hFFFF_FFFF);
      end else begin
        storeT s;
        s = storeQ.pop_front();
        chk("store_addr", MemAddr, s.addr);
        chk("store_data", MemWData, s.data);
      end
    end
    prevPending = !Rst && MemReq && !MemReady;
    prevAddr = MemAddr;
    prevWe = MemWe;
    prevWData = MemWData;
  end

  always @(posedge Clk) begin
    if (Rst) begin
      memCnt = 0;
      if (loadedGen != loadGen) begin
        for (int i = 0; i < MemWords; i++) ram[i] = prog[i];
        loadedGen = loadGen;
      end
    end else if (MemReq && MemReady) begin
      if (MemWe) ram[MemAddr[12:2]] = MemWData;
      memCnt = 0;
    end else if (MemReq) begin
      memCnt++;
    end
  end

  // Retire monitor
  int sinceRet = 0;
  bit firstRet = 1;
  always @(negedge Clk) begin
    if (Rst) begin
      sinceRet = 0;
      firstRet = 1;
    end else begin
      sinceRet++;
      if (Retire) begin
        if (expQ.size() == 0) begin
          chk("unexpected_retire_pc", PcOut, 32'hFFFF_FFFF);
        end else begin
          expT e;
          e = expQ.pop_front();
          chk("retire_pc", PcOut, e.pc);
          chk("write_reg", 32'(WriteReg), 32'(e.wreg));
          if (e.wr) chk("reg_value", dut.regs[e.wreg], e.regVal);
          if (e.aluChk) chk("alu_result", AluResult, e.aluVal);
          if (!firstRet) chk("cycles", 32'(sinceRet), 32'(e.cyc));
          firstRet = 0;
          sinceRet = 0;
        end
      end
    end
  end

  task automatic checkResetState(input string tag);
    chk({tag, "_rst_memreq"}, 32'(MemReq), 32'd0);
    chk({tag, "_rst_memwe"}, 32'(MemWe), 32'd0);
    chk({tag, "_rst_memaddr"}, MemAddr, 32'd0);
    chk({tag, "_rst_wdata"}, MemWData, 32'd0);
    chk({tag, "_rst_retire"}, 32'(Retire), 32'd0);
    chk({tag, "_rst_pc"}, PcOut, 32'd0);
    chk({tag, "_rst_alu"}, AluResult, 32'd0);
    chk({tag, "_rst_wreg"}, 32'(WriteReg), 32'd0);
  endtask

  task automatic runPhase(input string tag, input int limit, input int w);
    bit          halted, done;
    logic [31:0] haltPc;
    int          budget;
    Rst = 1;
    waitCfg = w;
    loadGen++;
    modelRun(limit, w, halted, haltPc);
    repeat (3) @(negedge Clk);
    #1;
    checkResetState(tag);
    Rst = 0;
    done = 0;
    budget = limit * (6 + 3 * w) + 40;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge Clk);
      #1;
      if (expQ.size() == 0) done = 1;
    end
    if (!done) chk({tag, "_timeout_pending"}, 32'(expQ.size()), 32'd0);
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    if (halted) begin
      repeat (10) @(negedge Clk);
      #1;
      chk({tag, "_illegal"}, 32'(Illegal), 32'd1);
      chk({tag, "_halt_pc"}, PcOut, haltPc);
      chk({tag, "_halt_memreq"}, 32'(MemReq), 32'd0);
    end
`endif
    chk({tag, "_stores_left"}, 32'(storeQ.size()), 32'd0);
    Rst = 1;
    expQ.delete();
    storeQ.delete();
    @(negedge Clk);
  endtask

  task automatic resetAbortPhase();
    bit          found, halted;
    logic [31:0] haltPc;
    Rst = 1;
    waitCfg = 3;
    fillRandom();
    prog[0] = encI(6'h08, 5'd0, 5'd5, 16'h0055);
    prog[1] = encI(6'h2B, 5'd0, 5'd5, 16'h0080);
    prog[32] = 32'hDEAD_BEEF;
    loadGen++;
    modelRun(1, 3, halted, haltPc);
    storeQ.delete();
    repeat (3) @(negedge Clk);
    Rst = 0;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge Clk);
      #1;
      if (MemReq && MemWe && memCnt == 1) found = 1;
    end
    chk("abort_reached_store_wait", 32'(found), 32'd1);
    Rst = 1;
    #1;
    checkResetState("abort");
    repeat (3) @(negedge Clk);
    chk("abort_store_suppressed", ram[32], 32'hDEAD_BEEF);
    chk("abort_addi_retired", 32'(expQ.size()), 32'd0);
    Rst = 0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge Clk);
      #1;
      if (MemReq) found = 1;
    end
    chk("abort_refetch_seen", 32'(found), 32'd1);
    chk("abort_refetch_addr", MemAddr, 32'd0);
    chk("abort_refetch_we", 32'(MemWe), 32'd0);
    Rst = 1;
    expQ.delete();
    @(negedge Clk);
  endtask

  initial begin
    Rst = 1;

    fillRandom();
    prog[0] = encI(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = encI(6'h08, 5'd0, 5'd2, 16'd7);
    prog[2] = encR(5'd1, 5'd2, 5'd3, 6'h20);
    runPhase("basic", 3, 0);

    fillRandom();
    prog[0] = encI(6'h08, 5'd0, 5'd3, 16'd12);
    prog[1] = encI(6'h2B, 5'd0, 5'd3, 16'h0040);
    prog[2] = encI(6'h23, 5'd0, 5'd4, 16'h0040);
    runPhase("swlw", 3, 2);

    for (int k = 0; k < 2; k++) begin
      fillRandom();
      for (int i = 0; i < 4; i++) prog[i] = encI(6'h08, 5'd0, 5'd1, 16'd3);
      prog[4] = encI((k == 0) ? 6'h04 : 6'h05, 5'd1, 5'd1, 16'd2);
      prog[5] = encI(6'h08, 5'd0, 5'd2, 16'd1);
      prog[6] = encI(6'h08, 5'd0, 5'd2, 16'd2);
      prog[7] = encI(6'h08, 5'd0, 5'd2, 16'd3);
      runPhase((k == 0) ? "beq" : "bne", 6, 0);
    end

    fillRandom();
    for (int i = 0; i < 8; i++) prog[i] = encI(6'h08, 5'd0, 5'd1, 16'(i));
    prog[8] = {6'h02, 26'h100};
    prog[256] = encI(6'h08, 5'd0, 5'd0, 16'd9);
    prog[257] = encI(6'h08, 5'd0, 5'd2, 16'd3);
    runPhase("jump", 11, 1);

    fillRandom();
    prog[0] = encI(6'h08, 5'd0, 5'd1, 16'hFFFF);
    prog[1] = encI(6'h08, 5'd0, 5'd2, 16'd1);
    prog[2] = encR(5'd1, 5'd2, 5'd3, 6'h2A);
    prog[3] = encI(6'h0D, 5'd0, 5'd4, 16'hFFFF);
    prog[4] = 32'hFC00_0000;
    prog[5] = encR(5'd1, 5'd2, 5'd5, 6'h3F);
    prog[6] = encI(6'h08, 5'd0, 5'd5, 16'd1);
    runPhase("slt_ori_rsvd", 7, 0);

    resetAbortPhase();

    for (int p = 0; p < 4; p++) begin
      fillRandom();
      runPhase("random", 100, (p < 3) ? p : $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle.md
Name: mips_multicycle

Overview:
- Multicycle MIPS-subset core. It is the successor to the single-cycle top and is built as one FSM-sequenced datapath.
- Instructions and data share one memory port with a req/ready handshake, so the core tolerates wait states.
- Contains its own register file and ALU.
- Sits between the testbench/SoC memory model and the debug observers, replacing the monocycle top.

Parameters:
- WIDTH, 32, datapath/register/address width; must be ≥ 32, with the instruction always in the low 32 bits.
- NREGS, 32, number of architectural registers; power of 2, ≤ 32; register address uses low log2(NREGS) bits of rs/rt/rd.
- RESET_PC, 0, Pc value loaded on reset.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- MemReq  out  1  memory request valid.
- MemWe  out  1  1 = store, 0 = load/fetch; valid while MemReq.
- MemAddr  out  WIDTH  byte address, word aligned.
- MemWData  out  WIDTH  store data.
- MemRData  in  WIDTH  read data; valid when MemReady=1.
- MemReady  in  1  completes the current request this cycle.
- PcOut  out  WIDTH  current Pc.
- AluResult  out  WIDTH  registered ALU output.
- WriteReg  out  5  destination of last register write.
- Retire  out  1  one-cycle pulse when an instruction completes.

Behaviour:
- Reset (async, immediate):
  - Pc=RESET_PC; state=FETCH.
  - MemReq, MemWe, MemAddr, MemWData, AluResult, WriteReg, Retire = 0.
  - All registers = 0.
  - Reset mid-request aborts it; no register or memory side effect may complete after Rst asserts.
- Handshake:
  - MemReq, MemWe, MemAddr and MemWData stay stable from assertion until the cycle MemReady=1; MemReq drops the next cycle.
  - MemReady while MemReq=0 is ignored.
  - Zero-wait memory (MemReady=1 combinationally with MemReq) completes in 1 cycle.
- States:
  - FETCH: MemReq=1, MemAddr=Pc. On MemReady: IR<=MemRData[31:0], Pc<=Pc+4 → DECODE.
  - DECODE: A<=R[rs], B<=R[rt]. ALUOut<=Pc+(sext(imm)<<2). Next state by opcode.
  - EXEC_R: ALUOut<=A op B → WB_R.
  - EXEC_I: ALUOut<=A op ext(imm) → WB_I, or → MEM_RD / MEM_WR for lw/sw.
  - MEM_RD: MemReq=1, MemWe=0, MemAddr=ALUOut. On MemReady: MDR<=MemRData → WB_MEM.
  - MEM_WR: MemReq=1, MemWe=1, MemAddr=ALUOut, MemWData=B. On MemReady: Retire → FETCH.
  - BRANCH: compare A,B. beq taken if equal; bne taken if unequal. If taken, Pc<=ALUOut. Retire → FETCH.
  - JUMP: Pc<={Pc[WIDTH-1:28], IR[25:0], 2'b00}. Retire → FETCH.
  - WB_R / WB_I / WB_MEM: R[dest]<=value; WriteReg<=dest; Retire → FETCH.
- ISA: each mnemonic is followed by its opcode or funct, a colon, then the operation. Operations on unlisted (reserved) opcode/funct values are specified under Optional Feature.
  - R-type, op 0x00, by funct:
    - add 0x20: rd = rs + rt.
    - sub 0x22: rd = rs − rt.
    - and 0x24: rd = rs & rt.
    - or 0x25: rd = rs | rt.
    - slt 0x2A: signed compare, result 1 or 0.
  - I-type, by opcode:
    - addi 0x08: sign-extended immediate.
    - ori 0x0D: zero-extended immediate.
    - lw 0x23.
    - sw 0x2B.
    - beq 0x04.
    - bne 0x05.
    - j 0x02.
- Cycle counts with zero-wait memory: R/addi/ori 4, lw 5, sw 4, beq/bne/j 3. Each memory wait cycle adds 1.
- Arithmetic: modulo 2^WIDTH, no overflow trap.
- Register 0: always reads 0; writes to it are discarded, but WriteReg still updates.
- Address alignment: MemAddr low 2 bits are forced to 0.
- Pc wraps modulo 2^WIDTH.

Optional Feature:
- Macro: MIPS_MC_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode/funct → state HALT.
  - HALT holds Pc at the faulting instruction address (Pc−4) and asserts output Illegal (1 bit, reset 0) high.
  - HALT is left only via Rst.
- Undefined:
  - Unknown instructions execute as nop: DECODE → FETCH with a Retire pulse, 2 cycles plus fetch waits.
  - No Illegal port exists.

Test Plan:
- Reset, then zero-wait memory holding addi $1,$0,5 / addi $2,$0,7 / add $3,$1,$2 → R3=12 after the 3rd Retire. PcOut=12. The add takes exactly 4 cycles.
- sw $3,0x40($0) then lw $4,0x40($0) with 2 wait cycles on every access → store at MemAddr=0x40 with MemWData=12 (address and data held 3 cycles). R4=12. lw takes 9 cycles.
- beq $1,$1,+2 at Pc=0x10 → next fetch address 0x1C. bne $1,$1,+2 at 0x10 → next fetch 0x14. Both take 3 cycles.
- j 0x100 at Pc=0x20 → next MemAddr 0x400. addi $0,$0,9 → R0 still reads 0, WriteReg=0.
- Assert Rst during a MEM_WR wait cycle → MemReq=0 the same cycle. After release, first fetch is at RESET_PC and the store never completes.
- slt with A=0xFFFFFFFF, B=1 → 1. ori with imm 0xFFFF on $0 → 0x0000FFFF. With MIPS_MC_ILLEGAL_TRAP_EN, opcode 0x3F → Illegal=1 and Pc frozen.
